tcp_bus_arbiter: RTL and testbench

- Shares the single tcpBus command port of the AXI4 master bridge between NUM_REQ independent requesters, e.g. two DPI socket servers, or a DPI server plus an on-chip test sequencer.
- Per-transaction round-robin arbitration; the grant stays locked until the transaction completes.
- Captures each winner's addr/size, then routes that requester's write-data stream, read-data stream and response to and from the bridge.
- Sits between the requesters and the AXI master bridge, in the same clock domain.

---
 rtl/tcp_bus_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_tcp_bus_arbiter.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_bus_arbiter.sv
// tcp_bus_arbiter
// Shares the single tcpBus command port of the AXI master bridge between
// NUM_REQ requesters. Arbitration is round-robin per transaction. The grant
// stays locked until the write response or the last read beat. The winner's
// data and response streams are then routed to and from the bridge.
//
// Ports
//   clk, reset           : system clock, synchronous active-high reset
//   req_cmd_*            : per-requester command valid/ready/write/addr/size
//   req_wdata_*          : per-requester write beat stream (to bridge)
//   req_rdata_*          : per-requester read beat stream (rdata broadcast)
//   req_rsp_*            : per-requester response pulse, payload broadcast
//   tcpBus_*             : bridge-side command, data and response port
//   grant                : one-hot current owner, 0 when idle
//   abort                : one-cycle pulse when the watchdog kills a transaction
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; arbitrate and accept one command
// WDATA | forwarding write beats from the owner until last
// WRSP  | waiting for the bridge write response
// RDATA | forwarding read beats to the owner until last
module tcp_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_cmd_valid,
    output logic [NUM_REQ-1:0]        req_cmd_ready,
    input  logic [NUM_REQ-1:0]        req_cmd_write,
    input  logic [32*NUM_REQ-1:0]     req_addr,
    input  logic [32*NUM_REQ-1:0]     req_size,
    input  logic [NUM_REQ-1:0]        req_wdata_valid,
    output logic [NUM_REQ-1:0]        req_wdata_ready,
    input  logic [NUM_REQ-1:0]        req_wdata_last,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_rdata_valid,
    input  logic [NUM_REQ-1:0]        req_rdata_ready,
    output logic [NUM_REQ-1:0]        req_rdata_last,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]        req_rsp_valid,
    output logic [1:0]                req_rsp_payload,
    output logic [31:0]               tcpBus_addr,
    output logic [31:0]               tcpBus_size,
    output logic                      tcpBus_wdata_valid,
    input  logic                      tcpBus_wdata_ready,
    output logic                      tcpBus_wdata_payload_last,
    output logic [DATA_W-1:0]         tcpBus_wdata_payload_fragment,
    input  logic                      tcpBus_rdata_valid,
    output logic                      tcpBus_rdata_ready,
    input  logic                      tcpBus_rdata_payload_last,
    input  logic [DATA_W-1:0]         tcpBus_rdata_payload_fragment,
    input  logic                      tcpBus_rsp_valid,
    input  logic [1:0]                tcpBus_rsp_payload,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      abort
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT > 1) ? TIMEOUT - 1 : 0);
    localparam bit WD_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, WDATA, WRSP, RDATA} state_t;

    state_t             state;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [31:0]        addr_q;
    logic [31:0]        size_q;
    logic [WD_W-1:0]    wd_cnt;
    logic               abort_q;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   win_next;
    logic [NUM_REQ-1:0] win_oh;
    logic [31:0]        win_addr;
    logic [31:0]        win_size;
    logic               win_write;

    logic               g_wvalid;
    logic               g_wlast;
    logic [DATA_W-1:0]  g_wdata;
    logic               g_rready;

    logic               active;
    logic               wdata_hs;
    logic               rdata_hs;
    logic               any_hs;
    logic               finish;

    // Round-robin search: first pass covers indices >= rr_ptr, second pass
    // wraps around to the lower indices.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!win_found && req_cmd_valid[j] && (IDX_W'(j) >= rr_ptr)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!win_found && req_cmd_valid[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        win_oh        = '0;
        win_next      = '0;
        win_addr      = '0;
        win_size      = '0;
        win_write     = 1'b0;
        req_cmd_ready = '0;
        g_wvalid      = 1'b0;
        g_wlast       = 1'b0;
        g_wdata       = '0;
        g_rready      = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_idx == IDX_W'(j)) begin
                win_oh[j]        = 1'b1;
                win_next         = (j == NUM_REQ - 1) ? '0 : IDX_W'(j + 1);
                win_addr         = req_addr[32*j +: 32];
                win_size         = req_size[32*j +: 32];
                win_write        = req_cmd_write[j];
                req_cmd_ready[j] = (state == IDLE) && win_found;
            end
            if (gidx == IDX_W'(j)) begin
                g_wvalid = req_wdata_valid[j];
                g_wlast  = req_wdata_last[j];
                g_wdata  = req_wdata[DATA_W*j +: DATA_W];
                g_rready = req_rdata_ready[j];
            end
        end
    end

    // During the abort cycle all bridge handshakes are suppressed so that no
    // beat slips through while the owner is being released.
    assign active = !abort_q;

    assign tcpBus_addr                   = addr_q;
    assign tcpBus_size                   = size_q;
    assign tcpBus_wdata_valid            = (state == WDATA) && active && g_wvalid;
    assign tcpBus_wdata_payload_last     = (state == WDATA) && g_wlast;
    assign tcpBus_wdata_payload_fragment = g_wdata;
    assign tcpBus_rdata_ready            = (state == RDATA) && active && g_rready;

    assign req_wdata_ready = ((state == WDATA) && active && tcpBus_wdata_ready) ? grant : '0;
    assign req_rdata_valid = ((state == RDATA) && active && tcpBus_rdata_valid) ? grant : '0;
    assign req_rdata_last  = ((state == RDATA) && active && tcpBus_rdata_payload_last) ? grant : '0;
    assign req_rdata       = tcpBus_rdata_payload_fragment;

    // grant is zero in IDLE, so a stray bridge response is dropped there.
    assign req_rsp_valid   = (abort_q || tcpBus_rsp_valid) ? grant : '0;
    assign req_rsp_payload = abort_q ? 2'b10 : tcpBus_rsp_payload;
    assign abort           = abort_q;

    assign wdata_hs = tcpBus_wdata_valid && tcpBus_wdata_ready;
    assign rdata_hs = tcpBus_rdata_valid && tcpBus_rdata_ready;
    assign any_hs   = wdata_hs || rdata_hs || tcpBus_rsp_valid;
    assign finish   = ((state == WRSP) && tcpBus_rsp_valid) ||
                      (rdata_hs && tcpBus_rdata_payload_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            gidx    <= '0;
            rr_ptr  <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            wd_cnt  <= '0;
            abort_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (win_found) begin
                        addr_q <= win_addr;
                        size_q <= win_size;
                        grant  <= win_oh;
                        gidx   <= win_idx;
                        rr_ptr <= win_next;
                        wd_cnt <= WD_LOAD;
                        state  <= win_write ? WDATA : RDATA;
                    end
                end
                default: begin
                    if (abort_q) begin
                        abort_q <= 1'b0;
                        grant   <= '0;
                        state   <= IDLE;
                    end else begin
                        if (finish) begin
                            grant <= '0;
                            state <= IDLE;
                        end else if (wdata_hs && tcpBus_wdata_payload_last) begin
                            state <= WRSP;
                        end
                        // Down-counter; abort is registered one cycle after
                        // reaching terminal count so it lands on cycle TIMEOUT.
                        if (any_hs) begin
                            wd_cnt <= WD_LOAD;
                        end else if (WD_EN && (wd_cnt <= WD_W'(1))) begin
                            abort_q <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt - WD_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_bus_arbiter.sv
module tb_tcp_bus_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] req_cmd_valid, req_cmd_ready, req_cmd_write;
    logic [63:0]   req_addr, req_size;
    logic [NR-1:0] req_wdata_valid, req_wdata_ready, req_wdata_last;
    logic [63:0]   req_wdata;
    logic [NR-1:0] req_rdata_valid, req_rdata_ready, req_rdata_last;
    logic [DW-1:0] req_rdata;
    logic [NR-1:0] req_rsp_valid;
    logic [1:0]    req_rsp_payload;
    logic [31:0]   tcpBus_addr, tcpBus_size;
    logic          tcpBus_wdata_valid, tcpBus_wdata_ready, tcpBus_wdata_payload_last;
    logic [DW-1:0] tcpBus_wdata_payload_fragment;
    logic          tcpBus_rdata_valid, tcpBus_rdata_ready, tcpBus_rdata_payload_last;
    logic [DW-1:0] tcpBus_rdata_payload_fragment;
    logic          tcpBus_rsp_valid;
    logic [1:0]    tcpBus_rsp_payload;
    logic [NR-1:0] grant;
    logic          abort;

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 1'b0;

    // Scoreboards: {last, data} at bridge; {req, last, data} at requester;
    // {req, payload} for responses.
    logic [DW:0]   exp_w[$];
    logic [DW+1:0] exp_r[$];
    logic [2:0]    exp_rsp[$];

    tcp_bus_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
        .req_cmd_write(req_cmd_write), .req_addr(req_addr), .req_size(req_size),
        .req_wdata_valid(req_wdata_valid), .req_wdata_ready(req_wdata_ready),
        .req_wdata_last(req_wdata_last), .req_wdata(req_wdata),
        .req_rdata_valid(req_rdata_valid), .req_rdata_ready(req_rdata_ready),
        .req_rdata_last(req_rdata_last), .req_rdata(req_rdata),
        .req_rsp_valid(req_rsp_valid), .req_rsp_payload(req_rsp_payload),
        .tcpBus_addr(tcpBus_addr), .tcpBus_size(tcpBus_size),
        .tcpBus_wdata_valid(tcpBus_wdata_valid), .tcpBus_wdata_ready(tcpBus_wdata_ready),
        .tcpBus_wdata_payload_last(tcpBus_wdata_payload_last),
        .tcpBus_wdata_payload_fragment(tcpBus_wdata_payload_fragment),
        .tcpBus_rdata_valid(tcpBus_rdata_valid), .tcpBus_rdata_ready(tcpBus_rdata_ready),
        .tcpBus_rdata_payload_last(tcpBus_rdata_payload_last),
        .tcpBus_rdata_payload_fragment(tcpBus_rdata_payload_fragment),
        .tcpBus_rsp_valid(tcpBus_rsp_valid), .tcpBus_rsp_payload(tcpBus_rsp_payload),
        .grant(grant), .abort(abort)
    );

    always #5 clk = ~clk;

    // Monitor: pops the scoreboards on every DUT-side handshake.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            tests_run++;
            if (((req_rdata_valid | req_rdata_last | req_wdata_ready | req_rsp_valid) & ~grant) !== '0) begin
                tests_failed++;
                $display("FAIL leak_to_ungranted: rv=%b rl=%b wr=%b rsp=%b grant=%b required no bits outside grant",
                         req_rdata_valid, req_rdata_last, req_wdata_ready, req_rsp_valid, grant);
            end
            if (tcpBus_wdata_valid && tcpBus_wdata_ready) begin
                tests_run++;
                if (exp_w.size() == 0) begin
                    tests_failed++;
                    $display("FAIL wbeat_unexpected: got %h required none", tcpBus_wdata_payload_fragment);
                end else begin
                    logic [DW:0] e;
                    e = exp_w.pop_front();
                    if ({tcpBus_wdata_payload_last, tcpBus_wdata_payload_fragment} !== e) begin
                        tests_failed++;
                        $display("FAIL wbeat: got %h required %h",
                                 {tcpBus_wdata_payload_last, tcpBus_wdata_payload_fragment}, e);
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_rdata_valid[i] && req_rdata_ready[i]) begin
                    tests_run++;
                    if (exp_r.size() == 0) begin
                        tests_failed++;
                        $display("FAIL rbeat_unexpected: req %0d got %h required none", i, req_rdata);
                    end else begin
                        logic [DW+1:0] e;
                        e = exp_r.pop_front();
                        if ({1'(i), req_rdata_last[i], req_rdata} !== e) begin
                            tests_failed++;
                            $display("FAIL rbeat: got %h required %h", {1'(i), req_rdata_last[i], req_rdata}, e);
                        end
                    end
                end
                if (req_rsp_valid[i]) begin
                    tests_run++;
                    if (exp_rsp.size() == 0) begin
                        tests_failed++;
                        $display("FAIL rsp_unexpected: req %0d payload %b required none", i, req_rsp_payload);
                    end else begin
                        logic [2:0] e;
                        e = exp_rsp.pop_front();
                        if ({1'(i), req_rsp_payload} !== e) begin
                            tests_failed++;
                            $display("FAIL rsp: got %b required %b", {1'(i), req_rsp_payload}, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_cmd_valid = '0; req_cmd_write = '0; req_addr = '0; req_size = '0;
        req_wdata_valid = '0; req_wdata_last = '0; req_wdata = '0; req_rdata_ready = '0;
        tcpBus_wdata_ready = 1'b0; tcpBus_rdata_valid = 1'b0; tcpBus_rdata_payload_last = 1'b0;
        tcpBus_rdata_payload_fragment = '0; tcpBus_rsp_valid = 1'b0; tcpBus_rsp_payload = '0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b00 || abort !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_grant_abort: got %b/%b required 00/0", grant, abort);
        end
        tests_run++;
        if (tcpBus_addr !== 32'h0 || tcpBus_size !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_addr_size: got %h/%h required 0/0", tcpBus_addr, tcpBus_size);
        end
        tests_run++;
        if ({req_cmd_ready, req_wdata_ready, req_rdata_valid, req_rsp_valid,
             tcpBus_wdata_valid, tcpBus_rdata_ready} !== '0) begin
            tests_failed++;
            $display("FAIL reset_handshakes: cr=%b wr=%b rv=%b rsp=%b bwv=%b brr=%b required all 0",
                     req_cmd_ready, req_wdata_ready, req_rdata_valid, req_rsp_valid,
                     tcpBus_wdata_valid, tcpBus_rdata_ready);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        req_cmd_valid = 2'b01; req_cmd_write = 2'b01;
        req_addr[31:0] = 32'h1000; req_size[31:0] = 32'd32;
        @(negedge clk);
        tests_run++;
        if (req_cmd_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL wr_cmd_ready: got %b required 01", req_cmd_ready);
        end
        step();
        req_cmd_valid = '0;
        tcpBus_wdata_ready = 1'b1;
        req_wdata_valid = 2'b01; req_wdata[31:0] = 32'hA5A5_0001; req_wdata_last = 2'b00;
        exp_w.push_back({1'b0, 32'hA5A5_0001});
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b01) begin
            tests_failed++;
            $display("FAIL wr_grant: got %b required 01", grant);
        end
        tests_run++;
        if (tcpBus_addr !== 32'h1000 || tcpBus_size !== 32'd32) begin
            tests_failed++;
            $display("FAIL wr_addr_size: got %h/%0d required 1000/32", tcpBus_addr, tcpBus_size);
        end
        step();
        req_wdata[31:0] = 32'hA5A5_0002; req_wdata_last = 2'b01;
        exp_w.push_back({1'b1, 32'hA5A5_0002});
        @(negedge clk);
        tests_run++;
        if (tcpBus_wdata_payload_last !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_last: got %b required 1", tcpBus_wdata_payload_last);
        end
        step();
        req_wdata_valid = '0; req_wdata_last = '0;
        @(negedge clk);
        tests_run++;
        if (tcpBus_addr !== 32'h1000 || tcpBus_wdata_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_rsp_wait: addr %h wvalid %b required 1000/0", tcpBus_addr, tcpBus_wdata_valid);
        end
        step();
        tcpBus_rsp_valid = 1'b1; tcpBus_rsp_payload = 2'b00;
        exp_rsp.push_back({1'b0, 2'b00});
        step();
        tcpBus_rsp_valid = 1'b0; tcpBus_wdata_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b00) begin
            tests_failed++;
            $display("FAIL wr_grant_release: got %b required 00", grant);
        end
        tests_run++;
        if (exp_w.size() + exp_r.size() + exp_rsp.size() != 0) begin
            tests_failed++;
            $display("FAIL wr_scoreboard_drain: got %0d left required 0", exp_w.size() + exp_r.size() + exp_rsp.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_cmd_valid = 2'b11; req_cmd_write = 2'b00;
        @(negedge clk);
        tests_run++;
        if (req_cmd_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL rr_first: got %b required 01", req_cmd_ready);
        end
        step();
        req_cmd_valid = 2'b10;
        tcpBus_rdata_valid = 1'b1; tcpBus_rdata_payload_last = 1'b1;
        tcpBus_rdata_payload_fragment = 32'h0000_00A0; req_rdata_ready = 2'b01;
        exp_r.push_back({1'b0, 1'b1, 32'h0000_00A0});
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b01 || req_cmd_ready !== 2'b00) begin
            tests_failed++;
            $display("FAIL rr_busy: grant %b ready %b required 01/00", grant, req_cmd_ready);
        end
        step();
        tcpBus_rdata_valid = 1'b0; req_rdata_ready = '0;
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b00 || req_cmd_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL rr_gap: grant %b ready %b required 00/10", grant, req_cmd_ready);
        end
        step();
        req_cmd_valid = '0;
        tcpBus_rdata_valid = 1'b1; tcpBus_rdata_payload_fragment = 32'h0000_00B1; req_rdata_ready = 2'b10;
        exp_r.push_back({1'b1, 1'b1, 32'h0000_00B1});
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b10) begin
            tests_failed++;
            $display("FAIL rr_second: got %b required 10", grant);
        end
        step();
        tcpBus_rdata_valid = 1'b0; req_rdata_ready = '0;
        req_cmd_valid = 2'b11;
        @(negedge clk);
        tests_run++;
        if (req_cmd_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL rr_ptr_wrap: got %b required 01", req_cmd_ready);
        end
        tests_run++;
        if (exp_w.size() + exp_r.size() + exp_rsp.size() != 0) begin
            tests_failed++;
            $display("FAIL rr_scoreboard_drain: got %0d left required 0", exp_w.size() + exp_r.size() + exp_rsp.size());
        end
    endtask

    task automatic test_read_backpressure();
        int b = 0, pushed = -1, nbeats = 0;
        bit done = 1'b0;
        logic [DW-1:0] f;
        do_reset();
        req_cmd_valid = 2'b01; req_cmd_write = 2'b00;
        step();
        req_cmd_valid = '0;
        tcpBus_rdata_valid = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            if (pushed != b) begin
                f = 32'hC0DE_0000 + 32'(b);
                tcpBus_rdata_payload_fragment = f;
                tcpBus_rdata_payload_last = (b == 3);
                exp_r.push_back({1'b0, (b == 3), f});
                pushed = b;
            end
            req_rdata_ready = (c % 2 == 0) ? 2'b01 : 2'b00;
            @(negedge clk);
            tests_run++;
            if (tcpBus_rdata_ready !== req_rdata_ready[0]) begin
                tests_failed++;
                $display("FAIL rd_ready_mirror: got %b required %b", tcpBus_rdata_ready, req_rdata_ready[0]);
            end
            tests_run++;
            if (req_rdata_valid[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL rd_req1_valid: got %b required 0", req_rdata_valid[1]);
            end
            if (tcpBus_rdata_valid && tcpBus_rdata_ready) begin
                nbeats++;
                if (b == 3) done = 1'b1;
                else b++;
            end
            step();
        end
        tcpBus_rdata_valid = 1'b0; tcpBus_rdata_payload_last = 1'b0; req_rdata_ready = '0;
        @(negedge clk);
        tests_run++;
        if (nbeats != 4) begin
            tests_failed++;
            $display("FAIL rd_beat_count: got %0d required 4", nbeats);
        end
        tests_run++;
        if (grant !== 2'b00) begin
            tests_failed++;
            $display("FAIL rd_release: got %b required 00", grant);
        end
        tests_run++;
        if (exp_w.size() + exp_r.size() + exp_rsp.size() != 0) begin
            tests_failed++;
            $display("FAIL rd_scoreboard_drain: got %0d left required 0", exp_w.size() + exp_r.size() + exp_rsp.size());
        end
    endtask

    task automatic test_reassert();
        do_reset();
        req_cmd_valid = 2'b10; req_cmd_write = 2'b00;
        req_addr[63:32] = 32'h2000; req_size[63:32] = 32'd16;
        @(negedge clk);
        tests_run++;
        if (req_cmd_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL ra_lone_req1: got %b required 10", req_cmd_ready);
        end
        step();
        req_cmd_valid = 2'b11;
        tcpBus_rdata_valid = 1'b1; tcpBus_rdata_payload_last = 1'b1;
        tcpBus_rdata_payload_fragment = 32'h0000_2001; req_rdata_ready = 2'b10;
        exp_r.push_back({1'b1, 1'b1, 32'h0000_2001});
        @(negedge clk);
        tests_run++;
        if (req_cmd_ready !== 2'b00 || tcpBus_addr !== 32'h2000) begin
            tests_failed++;
            $display("FAIL ra_completion: ready %b addr %h required 00/2000", req_cmd_ready, tcpBus_addr);
        end
        step();
        tcpBus_rdata_valid = 1'b0; req_rdata_ready = '0;
        @(negedge clk);
        tests_run++;
        if (req_cmd_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL ra_req0_wins: got %b required 01", req_cmd_ready);
        end
        step();
        tcpBus_rdata_valid = 1'b1; tcpBus_rdata_payload_fragment = 32'h0000_3001; req_rdata_ready = 2'b01;
        exp_r.push_back({1'b0, 1'b1, 32'h0000_3001});
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b01) begin
            tests_failed++;
            $display("FAIL ra_grant0: got %b required 01", grant);
        end
        step();
        tcpBus_rdata_valid = 1'b0; req_rdata_ready = '0;
        @(negedge clk);
        tests_run++;
        if (req_cmd_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL ra_req1_next: got %b required 10", req_cmd_ready);
        end
        tests_run++;
        if (exp_w.size() + exp_r.size() + exp_rsp.size() != 0) begin
            tests_failed++;
            $display("FAIL ra_scoreboard_drain: got %0d left required 0", exp_w.size() + exp_r.size() + exp_rsp.size());
        end
    endtask

    task automatic test_timeout();
        int abort_cycle = 0;
        do_reset();
        req_cmd_valid = 2'b01; req_cmd_write = 2'b01;
        step();
        req_cmd_valid = '0;
        tcpBus_wdata_ready = 1'b1;
        exp_rsp.push_back({1'b0, 2'b10});
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (abort === 1'b1) begin
                abort_cycle = k;
                tests_run++;
                if (req_wdata_ready !== 2'b00 || tcpBus_wdata_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL to_gating: wready %b wvalid %b required 00/0", req_wdata_ready, tcpBus_wdata_valid);
                end
                break;
            end
            step();
        end
        tests_run++;
        if (abort_cycle != 16) begin
            tests_failed++;
            $display("FAIL to_abort_cycle: got %0d required 16", abort_cycle);
        end
        step();
        tcpBus_wdata_ready = 1'b0;
        req_cmd_valid = 2'b01; req_cmd_write = 2'b00;
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b00 || abort !== 1'b0 || req_cmd_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL to_idle: grant %b abort %b ready %b required 00/0/01", grant, abort, req_cmd_ready);
        end
        tests_run++;
        if (exp_w.size() + exp_r.size() + exp_rsp.size() != 0) begin
            tests_failed++;
            $display("FAIL to_scoreboard_drain: got %0d left required 0", exp_w.size() + exp_r.size() + exp_rsp.size());
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        req_cmd_valid = 2'b01; req_cmd_write = 2'b00;
        step();
        req_cmd_valid = '0;
        tcpBus_rdata_valid = 1'b1; tcpBus_rdata_payload_last = 1'b0;
        tcpBus_rdata_payload_fragment = 32'h0000_4001; req_rdata_ready = 2'b01;
        exp_r.push_back({1'b0, 1'b0, 32'h0000_4001});
        step();
        tcpBus_rdata_payload_fragment = 32'h0000_4002; req_rdata_ready = 2'b00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_rdata_ready = 2'b01; tcpBus_wdata_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b00) begin
            tests_failed++;
            $display("FAIL rst_grant: got %b required 00", grant);
        end
        tests_run++;
        if ({req_rdata_valid, req_wdata_ready, req_rsp_valid, tcpBus_rdata_ready, tcpBus_wdata_valid} !== '0) begin
            tests_failed++;
            $display("FAIL rst_handshakes: rv=%b wr=%b rsp=%b brr=%b bwv=%b required all 0",
                     req_rdata_valid, req_wdata_ready, req_rsp_valid, tcpBus_rdata_ready, tcpBus_wdata_valid);
        end
        step();
        tcpBus_rdata_valid = 1'b0; req_rdata_ready = '0; tcpBus_wdata_ready = 1'b0;
        req_cmd_valid = 2'b11;
        @(negedge clk);
        tests_run++;
        if (req_cmd_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL rst_rr_ptr: got %b required 01", req_cmd_ready);
        end
        tests_run++;
        if (exp_w.size() + exp_r.size() + exp_rsp.size() != 0) begin
            tests_failed++;
            $display("FAIL rst_scoreboard_drain: got %0d left required 0", exp_w.size() + exp_r.size() + exp_rsp.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_backpressure();
        test_reassert();
        test_timeout();
        test_reset_mid_read();
        do_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
